lift_call_scheduler: RTL and testbench
======================================

Name: lift_call_scheduler

Overview:
Call-dispatch controller that sits in front of lift_fsm.
- Latches the 12 floor call buttons into a pending-request register.
- Picks the next target floor using the SCAN (elevator) policy and sequences door dwell at each served floor.
- Overrides everything with a ground-floor recall on fire alarm or power outage.
- lift_fsm consumes target_floor, dir_up, dir_down and door_open_req.

Parameters:
- NUM_FLOORS, 12, number of served floors; call vector width.
- FLOOR_W, 4, width of floor index / position.
- DWELL_CYCLES, 8, minimum cycles the door is held open per served stop (≥1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- floor_call_buttons  input  NUM_FLOORS  level call request per floor; bit i = floor i.
- elevator_position_sensor  input  FLOOR_W  current floor of car, valid 0..NUM_FLOORS-1.
- door_close_sensor  input  1  door fully closed.
- disability_sensor  input  1  extended-hold request; door stays open while high.
- fire_alarm_sensor  input  1  emergency recall.
- power_outage_sensor  input  1  emergency recall.
- target_floor  output  FLOOR_W  floor the car is being sent to.
- target_valid  output  1  target_floor is meaningful.
- dir_up  output  1  car commanded upward.
- dir_down  output  1  car commanded downward; never high together with dir_up.
- door_open_req  output  1  request lift_fsm to open/hold the door.
- pending_calls  output  NUM_FLOORS  registered pending-request vector.
- emergency_active  output  1  recall mode active.
- pos_error  output  1  position sensor out of range.

Behaviour:
- All outputs are registered. Reset (reset=0 at a clk edge) puts state in IDLE and drives every output to 0, including pending_calls, the dwell counter and target_floor.
- pending_calls update: next = (pending | floor_call_buttons) & ~clear_mask.
  - clear_mask is the one-hot of the current floor on the cycle SERVICE is entered.
  - If set and clear hit the same bit on the same cycle, clear wins.
  - Button-to-pending latency is 1 cycle.
- Let pos = elevator_position_sensor. Let above = any pending bit > pos, below = any pending bit < pos, here = pending[pos].
- State IDLE (dir_up=dir_down=0, target_valid=0):
  - here → SERVICE.
  - else above → MOVE_UP.
  - else below → MOVE_DOWN.
  - else stay.
  - If above and below are both set, up takes priority.
- State MOVE_UP (dir_up=1):
  - target_floor = lowest pending floor > pos; target_valid=1.
  - here → SERVICE.
  - else if no above: below → MOVE_DOWN, otherwise IDLE.
- State MOVE_DOWN (dir_down=1): mirror of MOVE_UP.
  - target_floor = highest pending floor < pos.
  - When no below: above → MOVE_UP, otherwise IDLE.
- State SERVICE (dir_up=dir_down=0, door_open_req=1, target_floor=pos):
  - On entry, clear pending[pos] and load the dwell counter with DWELL_CYCLES-1.
  - The counter decrements each cycle and saturates at 0.
  - A new call to pos during SERVICE reloads the counter and is not latched.
  - disability_sensor=1 freezes the counter.
  - Exit when counter==0 and disability_sensor=0: door_open_req drops. Remain in SERVICE (door_open_req=0) until door_close_sensor=1, then resume.
  - Resume goes to the previous direction state if calls remain that way, else the opposite direction, else IDLE.
- State EMERGENCY:
  - Entered from any state, one cycle after fire_alarm_sensor or power_outage_sensor is high; has priority over all transitions.
  - pending_calls cleared and further calls ignored; emergency_active=1.
  - target_floor=0, target_valid=1, dir_down=1 while pos>0.
  - At pos==0: dir_down=0, door_open_req=1.
  - Exit to IDLE one cycle after both emergency sensors are low; door_open_req drops on exit.
- pos_error:
  - Set when pos ≥ NUM_FLOORS. In that case the state holds, dir_up=dir_down=0, and pending still latches.
  - Clears the cycle after pos is valid again.
  - Emergency still overrides.
- Reset mid-move or mid-dwell: immediate return to IDLE with all requests lost.

Decomposition:
- Package lift_pkg holds:
  - NUM_FLOORS and FLOOR_W constants.
  - State enum: IDLE, MOVE_UP, MOVE_DOWN, SERVICE, EMERGENCY.
  - Direction enum: NONE, UP, DOWN.
- One sub-module, lift_call_select: combinational priority search.
  - Inputs: pending vector and pos.
  - Outputs: above, below, here, nearest_above, nearest_below.
  - The top holds the FSM, pending register and dwell counter.

Test Plan:
- Reset, pos=0, call bit 5 pulsed 1 cycle → pending=0x020 next cycle. Then MOVE_UP, target_floor=5, dir_up=1. At pos=5: SERVICE, pending=0x000, door_open_req high 8 cycles. With door_close_sensor=1 → IDLE.
- pos=4, calls 2, 7, 9 latched together → up first: target 7. After serving 7: target 9, then MOVE_DOWN with target 2. Order served is 7, 9, 2.
- In SERVICE at floor 3, disability_sensor high 20 cycles → door_open_req held for 20 + remaining dwell cycles. A repeat call on floor 3 mid-dwell reloads the counter to 7.
- MOVE_UP toward 10 at pos=6, fire_alarm_sensor=1 → next cycle EMERGENCY, pending=0, target 0, dir_down=1. At pos=0: door_open_req=1. Alarm low → IDLE with outputs 0.
- pos=4'hC while calls are pending → pos_error=1, dir_up=dir_down=0, state held. pos=3 → pos_error=0 next cycle and service resumes.
- Reset asserted during SERVICE with pending 0x801 → all outputs 0 next cycle. Calls pressed during reset are not latched.

Source files
------------

// File: rtl/lift_pkg.sv
// Shared constants, state/direction encodings and the SCAN resume rule
// for the lift call scheduler.
package lift_pkg;

    localparam int NUM_FLOORS = 12;
    localparam int FLOOR_W    = 4;

    typedef enum logic [2:0] {
        IDLE,
        MOVE_UP,
        MOVE_DOWN,
        SERVICE,
        EMERGENCY
    } lift_state_t;

    typedef enum logic [1:0] {
        NONE,
        UP,
        DOWN
    } lift_dir_t;

    // Keep travelling the same way while calls remain there, otherwise turn around.
    function automatic lift_state_t resume_state(lift_dir_t dir, logic above, logic below);
        lift_state_t s;
        if (dir == DOWN) begin
            if (below)      s = MOVE_DOWN;
            else if (above) s = MOVE_UP;
            else            s = IDLE;
        end else begin
            if (above)      s = MOVE_UP;
            else if (below) s = MOVE_DOWN;
            else            s = IDLE;
        end
        return s;
    endfunction

endpackage

// File: rtl/lift_call_select.sv
// Combinational search of the pending-call vector relative to the car position:
// presence flags and the nearest pending floor on each side.
module lift_call_select #(
    parameter int NUM_FLOORS = 12,
    parameter int FLOOR_W    = 4
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    pos,
    output logic                  above,
    output logic                  below,
    output logic                  here,
    output logic [FLOOR_W-1:0]    nearest_above,
    output logic [FLOOR_W-1:0]    nearest_below
);

    always_comb begin
        above         = 1'b0;
        below         = 1'b0;
        here          = 1'b0;
        nearest_above = '0;
        nearest_below = '0;
        // Descending scan so the lowest floor above pos is the last one kept.
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (FLOOR_W'(i) > pos)) begin
                above         = 1'b1;
                nearest_above = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && (FLOOR_W'(i) < pos)) begin
                below         = 1'b1;
                nearest_below = FLOOR_W'(i);
            end
            if (pending[i] && (FLOOR_W'(i) == pos)) here = 1'b1;
        end
    end

endmodule

// File: rtl/lift_call_scheduler.sv
// SCAN call dispatcher in front of lift_fsm: latches calls, chooses targets,
// sequences door dwell and performs ground-floor emergency recall.
//   IDLE      | no calls, car parked, door closed
//   MOVE_UP   | travelling up to nearest call above
//   MOVE_DOWN | travelling down to nearest call below
//   SERVICE   | stopped at a called floor: dwell, then wait for door closed
//   EMERGENCY | recall to floor 0, calls ignored
module lift_call_scheduler #(
    parameter int NUM_FLOORS   = lift_pkg::NUM_FLOORS,
    parameter int FLOOR_W      = lift_pkg::FLOOR_W,
    parameter int DWELL_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] floor_call_buttons,
    input  logic [FLOOR_W-1:0]    elevator_position_sensor,
    input  logic                  door_close_sensor,
    input  logic                  disability_sensor,
    input  logic                  fire_alarm_sensor,
    input  logic                  power_outage_sensor,
    output logic [FLOOR_W-1:0]    target_floor,
    output logic                  target_valid,
    output logic                  dir_up,
    output logic                  dir_down,
    output logic                  door_open_req,
    output logic [NUM_FLOORS-1:0] pending_calls,
    output logic                  emergency_active,
    output logic                  pos_error
);
    import lift_pkg::*;

    localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DWELL_RELOAD = CNT_W'(DWELL_CYCLES - 1);

    lift_state_t           state, state_next;
    lift_dir_t             prev_dir, prev_dir_next;
    logic [CNT_W-1:0]      dwell_cnt, dwell_next;
    logic [NUM_FLOORS-1:0] pending_next, clear_mask, pos_onehot;
    logic [FLOOR_W-1:0]    pos, target_next, nearest_above, nearest_below;
    logic                  above, below, here, pos_invalid, emerg_in, call_here;
    logic                  tvalid_next, up_next, down_next, door_next, emerg_next;

    assign pos         = elevator_position_sensor;
    assign pos_invalid = (pos >= FLOOR_W'(NUM_FLOORS));
    assign emerg_in    = fire_alarm_sensor | power_outage_sensor;
    assign pos_onehot  = pos_invalid ? '0 : (NUM_FLOORS'(1) << pos);
    assign call_here   = |(floor_call_buttons & pos_onehot);

    lift_call_select #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_select (
        .pending       (pending_calls),
        .pos           (pos),
        .above         (above),
        .below         (below),
        .here          (here),
        .nearest_above (nearest_above),
        .nearest_below (nearest_below)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state            <= IDLE;
            prev_dir         <= NONE;
            dwell_cnt        <= '0;
            pending_calls    <= '0;
            target_floor     <= '0;
            target_valid     <= 1'b0;
            dir_up           <= 1'b0;
            dir_down         <= 1'b0;
            door_open_req    <= 1'b0;
            emergency_active <= 1'b0;
            pos_error        <= 1'b0;
        end else begin
            state            <= state_next;
            prev_dir         <= prev_dir_next;
            dwell_cnt        <= dwell_next;
            pending_calls    <= pending_next;
            target_floor     <= target_next;
            target_valid     <= tvalid_next;
            dir_up           <= up_next;
            dir_down         <= down_next;
            door_open_req    <= door_next;
            emergency_active <= emerg_next;
            pos_error        <= pos_invalid;
        end
    end

    always_comb begin
        state_next    = state;
        prev_dir_next = prev_dir;
        dwell_next    = dwell_cnt;
        door_next     = door_open_req;
        target_next   = target_floor;
        tvalid_next   = target_valid;
        up_next       = 1'b0;
        down_next     = 1'b0;
        emerg_next    = 1'b0;
        clear_mask    = '0;

        if (emerg_in) begin
            state_next = EMERGENCY;
        end else if (state == EMERGENCY) begin
            state_next = IDLE;
        end else if (!pos_invalid) begin
            case (state)
                IDLE:      state_next = here ? SERVICE : resume_state(NONE, above, below);
                MOVE_UP:   state_next = here ? SERVICE : resume_state(UP, above, below);
                MOVE_DOWN: state_next = here ? SERVICE : resume_state(DOWN, above, below);
                SERVICE: begin
                    // A call at this floor reopens/extends the door instead of queueing.
                    if (call_here) begin
                        dwell_next = DWELL_RELOAD;
                        door_next  = 1'b1;
                    end else if (door_open_req && !disability_sensor) begin
                        if (dwell_cnt == '0) door_next  = 1'b0;
                        else                 dwell_next = dwell_cnt - CNT_W'(1);
                    end else if (!door_open_req && door_close_sensor) begin
                        state_next = resume_state(prev_dir, above, below);
                    end
                end
                default: state_next = IDLE;
            endcase
        end

        if (state_next == EMERGENCY) begin
            target_next   = '0;
            tvalid_next   = 1'b1;
            emerg_next    = 1'b1;
            down_next     = !pos_invalid && (pos != '0);
            door_next     = !pos_invalid && (pos == '0);
            prev_dir_next = NONE;
        end else if (!(pos_invalid && state != EMERGENCY)) begin
            case (state_next)
                IDLE: begin
                    target_next   = '0;
                    tvalid_next   = 1'b0;
                    door_next     = 1'b0;
                    prev_dir_next = NONE;
                end
                MOVE_UP: begin
                    target_next   = nearest_above;
                    tvalid_next   = 1'b1;
                    up_next       = 1'b1;
                    door_next     = 1'b0;
                    prev_dir_next = UP;
                end
                MOVE_DOWN: begin
                    target_next   = nearest_below;
                    tvalid_next   = 1'b1;
                    down_next     = 1'b1;
                    door_next     = 1'b0;
                    prev_dir_next = DOWN;
                end
                SERVICE: begin
                    target_next = pos;
                    tvalid_next = 1'b1;
                    clear_mask  = pos_onehot;
                    if (state != SERVICE) begin
                        door_next  = 1'b1;
                        dwell_next = DWELL_RELOAD;
                    end
                end
                default: ;
            endcase
        end

        if (state_next == EMERGENCY || state == EMERGENCY)
            pending_next = '0;
        else
            pending_next = (pending_calls | floor_call_buttons) & ~clear_mask;
    end

endmodule

// File: tb/tb_lift_call_scheduler.sv
// Directed bench for lift_call_scheduler: a cycle-by-cycle vector table plus
// hand sequences for door dwell extension and reset during service.
module tb_lift_call_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] floor_call_buttons;
    logic [3:0]  elevator_position_sensor;
    logic        door_close_sensor, disability_sensor, fire_alarm_sensor, power_outage_sensor;
    logic [3:0]  target_floor;
    logic        target_valid, dir_up, dir_down, door_open_req, emergency_active, pos_error;
    logic [11:0] pending_calls;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        rst;
        logic [11:0] btn;
        logic [3:0]  pos;
        logic [3:0]  inf;    // {close, disability, fire, power}
        logic [11:0] e_pend;
        logic [3:0]  e_tgt;
        logic [5:0]  e_flags; // {valid, up, down, door, emergency, pos_error}
    } vec_t;

    vec_t vecs[$];

    lift_call_scheduler dut (
        .clk                      (clk),
        .reset                    (reset),
        .floor_call_buttons       (floor_call_buttons),
        .elevator_position_sensor (elevator_position_sensor),
        .door_close_sensor        (door_close_sensor),
        .disability_sensor        (disability_sensor),
        .fire_alarm_sensor        (fire_alarm_sensor),
        .power_outage_sensor      (power_outage_sensor),
        .target_floor             (target_floor),
        .target_valid             (target_valid),
        .dir_up                   (dir_up),
        .dir_down                 (dir_down),
        .door_open_req            (door_open_req),
        .pending_calls            (pending_calls),
        .emergency_active         (emergency_active),
        .pos_error                (pos_error)
    );

    always #5 clk = ~clk;

    function automatic logic [21:0] outs();
        return {pending_calls, target_floor, target_valid, dir_up, dir_down,
                door_open_req, emergency_active, pos_error};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        checks++;
        if (dir_up && dir_down) begin
            failures++;
            $display("FAIL dir_exclusive: dir_up=%b dir_down=%b, required not both high", dir_up, dir_down);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [11:0] btn, input logic [3:0] pos,
                       input logic [3:0] inf, input logic [11:0] ep, input logic [3:0] et,
                       input logic [5:0] ef);
        vec_t v;
        v.rst = rst; v.btn = btn; v.pos = pos; v.inf = inf;
        v.e_pend = ep; v.e_tgt = et; v.e_flags = ef;
        vecs.push_back(v);
    endtask

    // Seven further door-open cycles after the entry cycle, then the door drops.
    task automatic add_dwell(input logic [3:0] pos, input logic [11:0] pend);
        for (int i = 0; i < 7; i++) add(1'b1, 12'h000, pos, 4'b0000, pend, pos, 6'b100100);
        add(1'b1, 12'h000, pos, 4'b0000, pend, pos, 6'b100000);
    endtask

    initial begin
        int hi;
        int n;
        reset = 1'b0;
        floor_call_buttons = '0;
        elevator_position_sensor = '0;
        door_close_sensor = 1'b0;
        disability_sensor = 1'b0;
        fire_alarm_sensor = 1'b0;
        power_outage_sensor = 1'b0;

        // Single call to floor 5 from floor 0
        add(1'b0, 12'h000, 4'd0, 4'b0000, 12'h000, 4'd0, 6'b000000);
        add(1'b0, 12'h020, 4'd0, 4'b0000, 12'h000, 4'd0, 6'b000000);
        add(1'b1, 12'h020, 4'd0, 4'b0000, 12'h020, 4'd0, 6'b000000);
        add(1'b1, 12'h000, 4'd0, 4'b0000, 12'h020, 4'd5, 6'b110000);
        add(1'b1, 12'h000, 4'd3, 4'b0000, 12'h020, 4'd5, 6'b110000);
        add(1'b1, 12'h000, 4'd5, 4'b0000, 12'h000, 4'd5, 6'b100100);
        add_dwell(4'd5, 12'h000);
        add(1'b1, 12'h000, 4'd5, 4'b1000, 12'h000, 4'd0, 6'b000000);
        // SCAN order from floor 4 with calls 2, 7, 9: serves 7, 9, then 2
        add(1'b1, 12'h284, 4'd4, 4'b0000, 12'h284, 4'd0, 6'b000000);
        add(1'b1, 12'h000, 4'd4, 4'b0000, 12'h284, 4'd7, 6'b110000);
        add(1'b1, 12'h000, 4'd7, 4'b0000, 12'h204, 4'd7, 6'b100100);
        add_dwell(4'd7, 12'h204);
        add(1'b1, 12'h000, 4'd7, 4'b1000, 12'h204, 4'd9, 6'b110000);
        add(1'b1, 12'h000, 4'd9, 4'b0000, 12'h004, 4'd9, 6'b100100);
        add_dwell(4'd9, 12'h004);
        add(1'b1, 12'h000, 4'd9, 4'b1000, 12'h004, 4'd2, 6'b101000);
        add(1'b1, 12'h000, 4'd2, 4'b0000, 12'h000, 4'd2, 6'b100100);
        add_dwell(4'd2, 12'h000);
        add(1'b1, 12'h000, 4'd2, 4'b1000, 12'h000, 4'd0, 6'b000000);
        // Fire recall while heading to floor 10
        add(1'b1, 12'h400, 4'd6, 4'b0000, 12'h400, 4'd0, 6'b000000);
        add(1'b1, 12'h000, 4'd6, 4'b0000, 12'h400, 4'd10, 6'b110000);
        add(1'b1, 12'h000, 4'd6, 4'b0010, 12'h000, 4'd0, 6'b101010);
        add(1'b1, 12'h008, 4'd3, 4'b0010, 12'h000, 4'd0, 6'b101010);
        add(1'b1, 12'h000, 4'd0, 4'b0010, 12'h000, 4'd0, 6'b100110);
        add(1'b1, 12'h000, 4'd0, 4'b0001, 12'h000, 4'd0, 6'b100110);
        add(1'b1, 12'h010, 4'd0, 4'b0000, 12'h000, 4'd0, 6'b000000);
        add(1'b1, 12'h000, 4'd0, 4'b0000, 12'h000, 4'd0, 6'b000000);
        // Position sensor out of range while moving to floor 3
        add(1'b1, 12'h008, 4'd0, 4'b0000, 12'h008, 4'd0, 6'b000000);
        add(1'b1, 12'h000, 4'd0, 4'b0000, 12'h008, 4'd3, 6'b110000);
        add(1'b1, 12'h100, 4'hC, 4'b0000, 12'h108, 4'd3, 6'b100001);
        add(1'b1, 12'h000, 4'hC, 4'b0000, 12'h108, 4'd3, 6'b100001);
        add(1'b1, 12'h000, 4'd3, 4'b0000, 12'h100, 4'd3, 6'b100100);

        foreach (vecs[i]) begin
            reset                    = vecs[i].rst;
            floor_call_buttons       = vecs[i].btn;
            elevator_position_sensor = vecs[i].pos;
            {door_close_sensor, disability_sensor, fire_alarm_sensor, power_outage_sensor} = vecs[i].inf;
            tick();
            checks++;
            if (outs() !== {vecs[i].e_pend, vecs[i].e_tgt, vecs[i].e_flags}) begin
                failures++;
                $display("FAIL vec%0d: got pend=%h tgt=%0d flags=%b, required pend=%h tgt=%0d flags=%b",
                         i, pending_calls, target_floor, outs() & 22'h3F,
                         vecs[i].e_pend, vecs[i].e_tgt, vecs[i].e_flags);
            end
        end

        // In SERVICE at floor 3 (counter 7): repeat call reload, then disability hold
        floor_call_buttons = '0;
        for (int i = 0; i < 3; i++) tick();
        floor_call_buttons = 12'h008;
        tick();
        floor_call_buttons = '0;
        check("repeat_call_not_latched", 32'(pending_calls), 32'h100);
        check("door_after_repeat", 32'(door_open_req), 32'd1);
        tick();
        tick();
        disability_sensor = 1'b1;
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (door_open_req) hi++;
        end
        check("door_held_by_disability", 32'(hi), 32'd20);
        disability_sensor = 1'b0;
        n = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (!door_open_req) break;
            n++;
        end
        check("remaining_dwell_after_hold", 32'(n), 32'd5);
        door_close_sensor = 1'b1;
        tick();
        door_close_sensor = 1'b0;
        check("resume_up_target", 32'(target_floor), 32'd8);
        check("resume_up_dir", 32'({dir_up, dir_down}), 32'b10);

        // Reset during SERVICE with calls pending on floors 0 and 11
        elevator_position_sensor = 4'd8;
        tick();
        check("service_at_8_door", 32'({door_open_req, target_floor}), 32'h18);
        floor_call_buttons = 12'h801;
        tick();
        floor_call_buttons = '0;
        check("pending_before_reset", 32'(pending_calls), 32'h801);
        reset = 1'b0;
        floor_call_buttons = 12'h0FF;
        tick();
        check("outputs_after_reset", 32'(outs()), 32'h0);
        reset = 1'b1;
        floor_call_buttons = '0;
        tick();
        check("calls_during_reset_dropped", 32'(outs()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
